// File: rtl/wb_resp_pkg.sv
// Shared types and constants for the Wishbone-to-native memory responder.
package wb_resp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2,
      ST_ERR  = 2'd3
   } state_e;

   localparam int unsigned DEFAULT_TIMEOUT = 16;
   localparam int unsigned CNT_W           = 8;

   // Keep only the byte lanes whose enable bit is set.
   function automatic logic [31:0] lane_mask(input logic [31:0] d, input logic [3:0] be);
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) begin
         m[8*i +: 8] = be[i] ? d[8*i +: 8] : 8'h00;
      end
      return m;
   endfunction

endpackage

// File: rtl/wb_resp_timeout_cnt.sv
// Wait-cycle counter for the native request phase, flags the last permitted cycle.
module wb_resp_timeout_cnt
   import wb_resp_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] limit,
   output logic             tc_c
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != {CNT_W{1'b1}})) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign tc_c = (cnt == (limit - CNT_W'(1)));

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone classic slave that forwards decoded accesses to a native ready-based memory port.
module wb_mem_responder
   import wb_resp_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'h2000_0000,
   parameter int unsigned SIZE_BYTES = 4096,
   parameter int unsigned TIMEOUT    = DEFAULT_TIMEOUT,
   parameter int unsigned AW         = $clog2(SIZE_BYTES / 4)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [31:0]   wb_adr_i,
   input  logic [31:0]   wb_dat_i,
   input  logic [3:0]    wb_sel_i,
   input  logic          wb_we_i,
   input  logic          wb_cyc_i,
   input  logic          wb_stb_i,
   output logic [31:0]   wb_dat_o,
   output logic          wb_ack_o,
   output logic          wb_err_o,
   output logic          mem_req_o,
   output logic          mem_we_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [3:0]    mem_be_o,
   output logic [31:0]   mem_wdata_o,
   input  logic [31:0]   mem_rdata_i,
   input  logic          mem_ready_i,
   output logic [7:0]    err_cnt_o
);

   localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);
   localparam logic [31:0]      WIN_SIZE  = 32'(SIZE_BYTES);

   state_e      state_q;
   state_e      state_d;
   logic [31:0] dat_d;
   logic [32:0] off_c;
   logic        hit_c;
   logic        accept_c;
   logic        suppress_c;
   logic        cnt_en_c;
   logic        tc_c;
   logic        aborted_q;

   // 33-bit subtraction so addresses below the base show up as a borrow.
   assign off_c      = {1'b0, wb_adr_i} - {1'b0, BASE_ADDR};
   assign hit_c      = !off_c[32] && (off_c[31:0] < WIN_SIZE) && (wb_sel_i != 4'd0);
   assign accept_c   = (state_q == ST_IDLE) && wb_cyc_i && wb_stb_i && hit_c;
   assign suppress_c = aborted_q || !wb_cyc_i;
   assign cnt_en_c   = (state_q == ST_REQ) && !mem_ready_i;

   wb_resp_timeout_cnt u_tmo (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (accept_c),
      .en      (cnt_en_c),
      .limit   (TMO_LIMIT),
      .tc_c    (tc_c)
   );

   always_comb begin
      state_d = state_q;
      dat_d   = '0;
      case (state_q)
         ST_IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               state_d = hit_c ? ST_REQ : ST_ERR;
            end
         end
         ST_REQ: begin
            // An aborted master still lets the native access finish, but gets no termination.
            if (mem_ready_i) begin
               if (suppress_c) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_ACK;
                  dat_d   = mem_we_o ? 32'h0 : lane_mask(mem_rdata_i, mem_be_o);
               end
            end else if (tc_c) begin
               state_d = suppress_c ? ST_IDLE : ST_ERR;
            end
         end
         ST_ACK:  state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         wb_dat_o    <= '0;
         wb_ack_o    <= 1'b0;
         wb_err_o    <= 1'b0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_be_o    <= '0;
         mem_wdata_o <= '0;
         err_cnt_o   <= '0;
         aborted_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         wb_dat_o  <= dat_d;
         wb_ack_o  <= (state_d == ST_ACK);
         wb_err_o  <= (state_d == ST_ERR);
         mem_req_o <= (state_d == ST_REQ);
         if (accept_c) begin
            mem_we_o    <= wb_we_i;
            mem_addr_o  <= off_c[AW+1:2];
            mem_be_o    <= wb_sel_i;
            mem_wdata_o <= wb_dat_i;
         end
         if (accept_c) begin
            aborted_q <= 1'b0;
         end else if ((state_q == ST_REQ) && !wb_cyc_i) begin
            aborted_q <= 1'b1;
         end
         if ((state_d == ST_ERR) && (err_cnt_o != 8'hFF)) begin
            err_cnt_o <= err_cnt_o + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_wb_mem_responder.sv
// Directed bench: transaction-level timing model plus a per-cycle output comparator.
module tb_wb_mem_responder;

   localparam int unsigned AW   = 10;
   localparam int          TMO  = 16;
   localparam longint      BASE = 64'h2000_0000;
   localparam longint      SIZE = 4096;

   logic          clk;
   logic          reset_n;
   logic [31:0]   wb_adr_i;
   logic [31:0]   wb_dat_i;
   logic [3:0]    wb_sel_i;
   logic          wb_we_i;
   logic          wb_cyc_i;
   logic          wb_stb_i;
   logic [31:0]   wb_dat_o;
   logic          wb_ack_o;
   logic          wb_err_o;
   logic          mem_req_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [3:0]    mem_be_o;
   logic [31:0]   mem_wdata_o;
   logic [31:0]   mem_rdata_i;
   logic          mem_ready_i;
   logic [7:0]    err_cnt_o;

   wb_mem_responder dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .wb_adr_i    (wb_adr_i),
      .wb_dat_i    (wb_dat_i),
      .wb_sel_i    (wb_sel_i),
      .wb_we_i     (wb_we_i),
      .wb_cyc_i    (wb_cyc_i),
      .wb_stb_i    (wb_stb_i),
      .wb_dat_o    (wb_dat_o),
      .wb_ack_o    (wb_ack_o),
      .wb_err_o    (wb_err_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_be_o    (mem_be_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i),
      .mem_ready_i (mem_ready_i),
      .err_cnt_o   (err_cnt_o)
   );

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [3:0]    be;
      logic          we;
      logic [31:0]   wd;
   } req_t;

   req_t        exp_req [int];
   logic [31:0] exp_ack [int];
   bit          exp_err [int];

   int          cyc_n = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   int          err_model = 0;
   bit          chk_en = 0;
   logic        prev_req = 1'b0;
   int          req_rise[$];
   logic [AW-1:0] rise_addr[$];
   int          ack_cyc[$];
   int          err_cyc[$];
   logic [31:0] last_ack_dat = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc_n++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc_n, act, exp);
      end
   endtask

   function automatic logic [31:0] byte_mask(input logic [31:0] d, input logic [3:0] s);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   // Per-cycle comparison against the expectation maps, on the falling edge.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         if (exp_err.exists(cyc_n) && err_model < 255) err_model++;
         chk("mem_req", 32'(mem_req_o), 32'(exp_req.exists(cyc_n)));
         if (exp_req.exists(cyc_n)) begin
            chk("mem_addr",  32'(mem_addr_o), 32'(exp_req[cyc_n].addr));
            chk("mem_be",    32'(mem_be_o),   32'(exp_req[cyc_n].be));
            chk("mem_we",    32'(mem_we_o),   32'(exp_req[cyc_n].we));
            chk("mem_wdata", mem_wdata_o,     exp_req[cyc_n].wd);
         end
         chk("wb_ack", 32'(wb_ack_o), 32'(exp_ack.exists(cyc_n)));
         chk("wb_err", 32'(wb_err_o), 32'(exp_err.exists(cyc_n)));
         chk("wb_dat", wb_dat_o, exp_ack.exists(cyc_n) ? exp_ack[cyc_n] : 32'h0);
         chk("err_cnt", 32'(err_cnt_o), 32'(err_model));
      end
      if (mem_req_o && !prev_req) begin
         req_rise.push_back(cyc_n);
         rise_addr.push_back(mem_addr_o);
      end
      prev_req = mem_req_o;
      if (wb_ack_o) begin
         ack_cyc.push_back(cyc_n);
         last_ack_dat = wb_dat_o;
      end
      if (wb_err_o) err_cyc.push_back(cyc_n);
   end

   // wt: ready arrives in REQ cycle wt+1 (negative = never); abort_at: REQ cycle index where cyc drops.
   task automatic txn(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input logic we, input logic [31:0] rdata, input int wt, input int abort_at,
                      output int c);
      bit   hit;
      int   last_req, resp, rdy_cyc, end_c, abort_cyc;
      req_t r;
      c         = cyc_n;
      rdy_cyc   = -1;
      abort_cyc = (abort_at >= 0) ? c + 1 + abort_at : 32'h3FFF_FFFF;
      hit = (longint'(adr) >= BASE) && (longint'(adr) < BASE + SIZE) && (sel != 4'h0);
      if (!hit) begin
         resp = c + 1;
         exp_err[resp] = 1'b1;
      end else begin
         if (wt >= 0 && wt < TMO) begin
            rdy_cyc  = c + 1 + wt;
            last_req = rdy_cyc;
         end else begin
            last_req = c + TMO;
         end
         r.addr = 10'((longint'(adr) - BASE) >> 2);
         r.be   = sel;
         r.we   = we;
         r.wd   = dat;
         for (int k = c + 1; k <= last_req; k++) exp_req[k] = r;
         resp = last_req + 1;
         if (abort_at < 0) begin
            if (rdy_cyc >= 0) exp_ack[resp] = we ? 32'h0 : byte_mask(rdata, sel);
            else              exp_err[resp] = 1'b1;
         end
      end
      end_c       = resp + 1;
      wb_adr_i    = adr;
      wb_dat_i    = dat;
      wb_sel_i    = sel;
      wb_we_i     = we;
      mem_rdata_i = rdata;
      for (int k = c; k < end_c; k++) begin
         wb_cyc_i    = (k < abort_cyc);
         wb_stb_i    = (k < abort_cyc);
         mem_ready_i = (k == rdy_cyc);
         @(posedge clk);
         #1;
      end
      wb_cyc_i    = 1'b0;
      wb_stb_i    = 1'b0;
      mem_ready_i = 1'b0;
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int k = 0; k < n; k++) begin
         mem_ready_i = rdy;
         @(posedge clk);
         #1;
      end
      mem_ready_i = 1'b0;
   endtask

   initial begin
      int c, c2, na, ne, nr;
      reset_n     = 1'b0;
      wb_adr_i    = '0;
      wb_dat_i    = '0;
      wb_sel_i    = '0;
      wb_we_i     = 1'b0;
      wb_cyc_i    = 1'b0;
      wb_stb_i    = 1'b0;
      mem_rdata_i = '0;
      mem_ready_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mem_req", 32'(mem_req_o), 32'h0);
      chk("rst_ack",     32'(wb_ack_o),  32'h0);
      chk("rst_err",     32'(wb_err_o),  32'h0);
      chk("rst_err_cnt", 32'(err_cnt_o), 32'h0);
      chk("rst_dat",     wb_dat_o,       32'h0);
      reset_n = 1'b1;
      chk_en  = 1'b1;
      idle(2, 1'b0);

      // Read hit, ready in the first REQ cycle.
      txn(32'h2000_0010, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, 0, -1, c);
      chk("rd_req_rise", 32'(req_rise[$]), 32'(c + 1));
      chk("rd_addr",     32'(rise_addr[$]), 32'd4);
      chk("rd_ack_lat",  32'(ack_cyc[$]),  32'(c + 2));
      chk("rd_data",     last_ack_dat,     32'hDEAD_BEEF);

      idle(3, 1'b1);

      // Byte write with three wait cycles.
      na = ack_cyc.size();
      txn(32'h2000_0FFC, 32'h00AB_0000, 4'b0100, 1'b1, 32'hFFFF_FFFF, 3, -1, c);
      chk("wr_addr",     32'(rise_addr[$]), 32'h3FF);
      chk("wr_ack_lat",  32'(ack_cyc[$]),  32'(c + 5));
      chk("wr_one_ack",  32'(ack_cyc.size() - na), 32'd1);
      chk("wr_dat_zero", last_ack_dat,     32'h0);

      // Partial-lane read at an unaligned address.
      txn(32'h2000_0013, 32'h0, 4'b1001, 1'b0, 32'h1122_3344, 1, -1, c);
      chk("part_addr", 32'(rise_addr[$]), 32'd4);
      chk("part_data", last_ack_dat,      32'h1100_0044);

      // Misses: past the window, sel=0 inside it, below the base.
      nr = req_rise.size();
      txn(32'h2000_1000, 32'h0, 4'hF, 1'b0, 32'h0, 0, -1, c);
      chk("miss_err_lat", 32'(err_cyc[$]), 32'(c + 1));
      chk("miss_err_cnt", 32'(err_cnt_o),  32'd1);
      txn(32'h2000_0040, 32'h0, 4'h0, 1'b0, 32'h0, 0, -1, c);
      chk("sel0_err_lat", 32'(err_cyc[$]), 32'(c + 1));
      chk("sel0_err_cnt", 32'(err_cnt_o),  32'd2);
      txn(32'h1FFF_FFFC, 32'h0, 4'hF, 1'b1, 32'h0, 0, -1, c);
      chk("below_err_cnt", 32'(err_cnt_o), 32'd3);
      chk("miss_no_req",   32'(req_rise.size()), 32'(nr));

      // Timeout with ready held low.
      txn(32'h2000_0100, 32'h5555_AAAA, 4'hF, 1'b1, 32'h0, -1, -1, c);
      chk("tmo_err_lat", 32'(err_cyc[$]), 32'(c + 17));
      chk("tmo_err_cnt", 32'(err_cnt_o),  32'd4);

      // Master abort: ready two cycles after cyc drops, then abort during a timeout.
      na = ack_cyc.size();
      ne = err_cyc.size();
      txn(32'h2000_0200, 32'h1234_5678, 4'hF, 1'b1, 32'h0, 2, 0, c);
      chk("abort_req_low", 32'(mem_req_o), 32'h0);
      txn(32'h2000_0204, 32'h0, 4'hF, 1'b0, 32'h0, -1, 3, c);
      chk("abort_no_ack",  32'(ack_cyc.size()), 32'(na));
      chk("abort_no_err",  32'(err_cyc.size()), 32'(ne));
      chk("abort_err_cnt", 32'(err_cnt_o),      32'd4);
      txn(32'h2000_0020, 32'h0, 4'hF, 1'b0, 32'hCAFE_F00D, 0, -1, c);
      chk("post_abort_ack", 32'(ack_cyc[$]), 32'(c + 2));

      // Back-to-back reads.
      txn(32'h2000_0000, 32'h0, 4'hF, 1'b0, 32'hA5A5_0001, 0, -1, c);
      txn(32'h2000_0004, 32'h0, 4'hF, 1'b0, 32'hA5A5_0002, 0, -1, c2);
      chk("b2b_req_gap", 32'(req_rise[$] - req_rise[$-1]), 32'd3);
      chk("b2b_ack_gap", 32'((ack_cyc[$] - ack_cyc[$-1]) > 1), 32'd1);
      chk("b2b_data",    last_ack_dat, 32'hA5A5_0002);

      // Error counter saturation.
      for (int i = 0; i < 300; i++) txn(32'h2000_0300, 32'h0, 4'hF, 1'b0, 32'h0, -1, -1, c);
      chk("err_cnt_sat", 32'(err_cnt_o), 32'd255);

      // Reset asserted in the middle of REQ.
      chk_en   = 1'b0;
      wb_adr_i = 32'h2000_0008;
      wb_sel_i = 4'hF;
      wb_we_i  = 1'b1;
      wb_cyc_i = 1'b1;
      wb_stb_i = 1'b1;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("pre_rst_req", 32'(mem_req_o), 32'h1);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_mid_req",     32'(mem_req_o), 32'h0);
      chk("rst_mid_err_cnt", 32'(err_cnt_o), 32'h0);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;
      na = ack_cyc.size();
      idle(6, 1'b1);
      idle(6, 1'b0);
      chk("rst_no_ack", 32'(ack_cyc.size()), 32'(na));
      exp_req.delete();
      exp_ack.delete();
      exp_err.delete();
      err_model = 0;
      chk_en    = 1'b1;
      txn(32'h2000_0FF0, 32'h0, 4'hF, 1'b0, 32'h0BAD_F00D, 0, -1, c);
      chk("post_rst_ack", 32'(ack_cyc[$]), 32'(c + 2));
      idle(2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
